dbus_uncached_slave: RTL and testbench
======================================

Name: dbus_uncached_slave

Overview:
- Slave end of the data-bus uncached channel.
- Accepts the uncached_read/uncached_write requests the CPU issues on the data bus and drives uncached_stall and uncached_rddata back.
- Converts each request into one transaction on a valid/ready memory port toward the uncached MMIO/AXI bridge.
- Single outstanding access; sits between the CPU memory stage and the uncached bridge, parallel to the D$.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles WAIT may last before forced completion; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- uncached_read  input  1  CPU uncached load request, held while stalled.
- uncached_write  input  1  CPU uncached store request, held while stalled.
- address  input  32  physical address, 4-byte aligned.
- wrdata  input  32  store data.
- byteenable  input  4  store byte lanes.
- uncached_stall  output  1  CPU must hold its request while high.
- uncached_rddata  output  32  load data, valid in the cycle stall is low after a read.
- mem_req_valid  output  1  memory request valid.
- mem_req_ready  input  1  memory request accepted.
- mem_req_write  output  1  1 = write, 0 = read.
- mem_req_addr  output  32  request address.
- mem_req_wdata  output  32  write data.
- mem_req_be  output  4  byte enables; 4'b1111 for reads.
- mem_resp_valid  input  1  response strobe, one cycle.
- mem_resp_rdata  input  32  response data.
- bus_error  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - mem_req_valid, mem_req_write, bus_error = 0.
  - mem_req_addr, mem_req_wdata, uncached_rddata, timeout counter = 0.
  - mem_req_be = 4'b0000.
  - Reset mid-transaction abandons it silently; a late mem_resp_valid arriving in IDLE is ignored.
- Request signal: req = uncached_read | uncached_write. If both are high, write wins and the read is ignored.
- uncached_stall = req & (state != DONE). It is combinational, so it rises in the same cycle a request appears.
- IDLE:
  - On req, latch address, wrdata, byteenable (reads latch be = 4'b1111) and the write flag.
  - Go to REQ; mem_req_valid is registered high starting the next cycle.
- REQ:
  - mem_req_valid = 1; the request fields are stable until handshake.
  - On mem_req_ready, go to WAIT and clear the counter.
  - valid may not drop or fields change before ready (AXI-style).
- WAIT:
  - mem_req_valid = 0.
  - On mem_resp_valid, capture mem_resp_rdata into uncached_rddata (writes leave it unchanged) and go to DONE.
  - Else the counter increments. When TIMEOUT_CYCLES != 0 and count == TIMEOUT_CYCLES-1: uncached_rddata = ERR_RDATA, bus_error pulses for one cycle, go to DONE.
- DONE:
  - Lasts exactly one cycle; stall is low, so the CPU consumes the result and advances.
  - Go to IDLE unconditionally. The request still visible this cycle is the completed one and is not re-issued.
- Back-to-back: a new request seen in IDLE the cycle after DONE starts immediately.
- Minimum latency with ready and resp both immediate: request cycle N, REQ N+1, WAIT N+2, DONE N+3 (stall low). Stall is high for 3 cycles.
- uncached_rddata holds its value until the next read completes or reset.
- The counter saturates and never wraps within a transaction.

Optional Feature:
- Macro: UNCACHED_WRITE_POST_EN.
- Defined:
  - Writes complete at the mem_req_ready handshake: REQ goes straight to DONE, so stall is 2 cycles minimum.
  - The matching write response is absorbed by a 1-bit pending flag.
  - A following request may enter REQ while the flag is set, but must not leave WAIT until the pending response has arrived. The next mem_resp_valid clears the flag and is not taken as the new response.
  - Timeout also clears the flag.
- Undefined: writes wait for mem_resp_valid exactly like reads.

Test Plan:
- Read 0x1FD0_F000, ready and resp immediate, rdata 0x1234_5678 -> stall high for exactly 3 cycles; mem_req_be = 4'hF; uncached_rddata = 0x1234_5678 in the stall-low cycle.
- Write 0x1FD0_F004, data 0xA5A5_A5A5, be 4'b0011, ready delayed 4 cycles -> valid held 5 cycles with constant addr/data/be; one request total; stall drops 1 cycle after resp.
- Read and write asserted together -> mem_req_write = 1; exactly one transaction.
- TIMEOUT_CYCLES = 8, no response -> bus_error pulses once; uncached_rddata = 0xDEAD_BEEF; stall drops; next request proceeds normally.
- rst_n asserted during WAIT, then a late resp -> all outputs at reset values immediately; no DONE; resp ignored.
- UNCACHED_WRITE_POST_EN: write then read back-to-back, write resp 3 cycles late -> write stall 2 cycles; the read does not complete on the write's response and returns its own data.

Source files
------------

// File: rtl/dbus_uncached_slave.sv
// Uncached data-bus slave: one CPU load/store -> one valid/ready memory transaction.
// Optional UNCACHED_WRITE_POST_EN: stores complete at the request handshake.
module dbus_uncached_slave #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uncached_read,
    input  logic        uncached_write,
    input  logic [31:0] address,
    input  logic [31:0] wrdata,
    input  logic [3:0]  byteenable,
    output logic        uncached_stall,
    output logic [31:0] uncached_rddata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_be,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_cnt;
    logic        w_req;
    logic        w_tmo;
    logic        w_block;

    assign w_req          = uncached_read | uncached_write;
    assign uncached_stall = w_req & (r_state != S_DONE);
    assign w_tmo          = TMO_EN && (r_cnt == TMO_LAST);

`ifdef UNCACHED_WRITE_POST_EN
    logic r_pend;
    // A response arriving while a posted write is outstanding belongs to it.
    assign w_block = r_pend;
`else
    assign w_block = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            mem_req_valid   <= 1'b0;
            mem_req_write   <= 1'b0;
            mem_req_addr    <= '0;
            mem_req_wdata   <= '0;
            mem_req_be      <= 4'b0000;
            uncached_rddata <= '0;
            bus_error       <= 1'b0;
`ifdef UNCACHED_WRITE_POST_EN
            r_pend          <= 1'b0;
`endif
        end else begin
            bus_error <= 1'b0;
`ifdef UNCACHED_WRITE_POST_EN
            if (mem_resp_valid && r_pend) begin
                r_pend <= 1'b0;
            end
`endif
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        mem_req_addr  <= address;
                        mem_req_wdata <= wrdata;
                        mem_req_be    <= uncached_write ? byteenable : 4'b1111;
                        mem_req_write <= uncached_write;
                        mem_req_valid <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= S_WAIT;
`ifdef UNCACHED_WRITE_POST_EN
                        // Only one posted write can be tracked at a time.
                        if (mem_req_write && !r_pend) begin
                            r_pend  <= 1'b1;
                            r_state <= S_DONE;
                        end
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid && !w_block) begin
                        if (!mem_req_write) begin
                            uncached_rddata <= mem_resp_rdata;
                        end
                        r_state <= S_DONE;
                    end else if (w_tmo) begin
                        uncached_rddata <= ERR_RDATA;
                        bus_error       <= 1'b1;
                        r_state         <= S_DONE;
`ifdef UNCACHED_WRITE_POST_EN
                        r_pend          <= 1'b0;
`endif
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_uncached_slave.sv
// Scoreboard bench for dbus_uncached_slave: random CPU traffic against a
// queue-based memory model; monitors check bus requests and completions.
module tb_dbus_uncached_slave;

    localparam int          TMO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        uncached_read;
    logic        uncached_write;
    logic [31:0] address;
    logic [31:0] wrdata;
    logic [3:0]  byteenable;
    logic        uncached_stall;
    logic [31:0] uncached_rddata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        bus_error;

    dbus_uncached_slave #(
        .TIMEOUT_CYCLES(TMO),
        .ERR_RDATA     (ERR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .uncached_read  (uncached_read),
        .uncached_write (uncached_write),
        .address        (address),
        .wrdata         (wrdata),
        .byteenable     (byteenable),
        .uncached_stall (uncached_stall),
        .uncached_rddata(uncached_rddata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_be     (mem_req_be),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .bus_error      (bus_error)
    );

    typedef struct {
        int          d;
        int          rd;
        bit          drop;
        logic [31:0] data;
    } tx_t;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } done_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    tx_t   tx_q[$];
    req_t  exp_req[$];
    done_t exp_done[$];
    rsp_t  rsp_q[$];

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    logic [31:0] last_rd = '0;
    bit          prev_wr = 1'b0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Memory model: per-transaction ready delay, in-order delayed responses.
    initial begin
        int   rdy_wait;
        int   last_due;
        int   due;
        tx_t  cur;
        rsp_t r;
        rdy_wait = -1;
        last_due = 0;
        cur = '{0, 0, 1'b0, 32'h0};
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_rdata = '0;
            if (!rst_n) begin
                rdy_wait = -1;
            end else if (mem_req_valid) begin
                if (rdy_wait < 0) begin
                    if (tx_q.size() > 0) cur = tx_q.pop_front();
                    else cur = '{0, 0, 1'b0, 32'h0};
                    rdy_wait = cur.d;
                end
                if (rdy_wait == 0) begin
                    mem_req_ready = 1'b1;
                    rdy_wait = -1;
                    if (!cur.drop) begin
                        due = cyc + 1 + cur.rd;
                        if (due <= last_due) due = last_due + 1;
                        last_due = due;
                        rsp_q.push_back('{due, cur.data});
                    end
                end else begin
                    rdy_wait--;
                end
            end
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                r = rsp_q.pop_front();
                mem_resp_valid = 1'b1;
                mem_resp_rdata = r.data;
            end
        end
    end

    // Request monitor: handshake contents and AXI-style stability.
    initial begin
        bit   p_valid;
        bit   p_ready;
        req_t p_req;
        req_t c_req;
        req_t e;
        p_valid = 1'b0;
        p_ready = 1'b0;
        p_req   = '0;
        forever begin
            @(negedge clk);
            c_req = '{mem_req_write, mem_req_addr, mem_req_wdata, mem_req_be};
            if (!rst_n) begin
                p_valid = 1'b0;
            end else begin
                if (p_valid && !p_ready) begin
                    chk("req_hold_valid", {127'b0, mem_req_valid}, 128'd1);
                    chk("req_hold_fields", {59'b0, c_req}, {59'b0, p_req});
                end
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_req.size() == 0) begin
                        chk("req_unexpected", 128'd1, 128'd0);
                    end else begin
                        e = exp_req.pop_front();
                        chk("req_fields", {59'b0, c_req}, {59'b0, e});
                    end
                end
                p_valid = mem_req_valid;
                p_ready = mem_req_ready;
                p_req   = c_req;
            end
        end
    end

    // Completion monitor: the stall-low cycle of a held request.
    initial begin
        done_t e;
        bit    done;
        forever begin
            @(negedge clk);
            done = rst_n && (uncached_read || uncached_write) && !uncached_stall;
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 128'd1, 128'd0);
                end else begin
                    e = exp_done.pop_front();
                    chk("done_rddata", {96'b0, uncached_rddata}, {96'b0, e.rdata});
                    chk("done_bus_error", {127'b0, bus_error}, {127'b0, e.err});
                end
            end else if (bus_error) begin
                chk("bus_error_stray", 128'd1, 128'd0);
            end
        end
    end

    function automatic int exp_lat(input bit w, input int d, input int rd,
                                   input bit drop);
        if (drop) return 2 + d + TMO;
`ifdef UNCACHED_WRITE_POST_EN
        if (prev_wr) return -1;
        if (w) return 2 + d;
`endif
        return 3 + d + rd;
    endfunction

    task automatic do_txn(input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input int d, input int rd, input bit drop,
                          input logic [31:0] data);
        int    lat;
        int    el;
        bit    ok;
        done_t e;
        el = exp_lat(w, d, rd, drop);
        tx_q.push_back('{d, rd, drop, data});
        exp_req.push_back('{w, a, wd, (w ? be : 4'hF)});
        e.err   = drop;
        e.rdata = drop ? ERR : (w ? last_rd : data);
        last_rd = e.rdata;
        exp_done.push_back(e);
        prev_wr = w;
        uncached_read  = r;
        uncached_write = w;
        address        = a;
        wrdata         = wd;
        byteenable     = be;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uncached_stall) lat++;
            else begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("stall_timeout", 128'd1, 128'd0);
        else if (el >= 0) chk("stall_cycles", 128'(lat), 128'(el));
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle(input int n);
        uncached_read  = 1'b0;
        uncached_write = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          k;
        bit          r;
        bit          w;
        bit          drop;
        int          d;
        int          rd;
        logic [31:0] a;
        uncached_read  = 1'b0;
        uncached_write = 1'b0;
        address        = '0;
        wrdata         = '0;
        byteenable     = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", {127'b0, mem_req_valid}, 128'd0);
        chk("rst_fields", {59'b0, mem_req_write, mem_req_addr, mem_req_wdata,
            mem_req_be}, 128'd0);
        chk("rst_rddata", {96'b0, uncached_rddata}, 128'd0);
        chk("rst_bus_error", {127'b0, bus_error}, 128'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        go_idle(1);

        do_txn(1, 0, 32'h1FD0_F000, 32'h0, 4'h0, 0, 0, 0, 32'h1234_5678);
        go_idle(1);
        do_txn(0, 1, 32'h1FD0_F004, 32'hA5A5_A5A5, 4'b0011, 4, 0, 0, 32'h0BAD_0001);
        go_idle(2);
        do_txn(1, 1, 32'h1FD0_F008, 32'h0F0F_0F0F, 4'b1100, 1, 1, 0, 32'h0BAD_0002);
        go_idle(1);
        do_txn(1, 0, 32'h1FD0_F00C, 32'h0, 4'h0, 0, 0, 1, 32'h0);
        do_txn(1, 0, 32'h1FD0_F010, 32'h0, 4'h0, 0, 2, 0, 32'h7777_1111);
        go_idle(1);

`ifdef UNCACHED_WRITE_POST_EN
        do_txn(0, 1, 32'h1FD0_F014, 32'h1111_2222, 4'hF, 0, 3, 0, 32'h0BAD_0003);
        do_txn(1, 0, 32'h1FD0_F018, 32'h0, 4'h0, 0, 0, 0, 32'hCAFE_F00D);
        go_idle(2);
        prev_wr = 1'b0;
`endif

        for (k = 0; k < 40; k++) begin
            w    = ($urandom_range(0, 2) != 0) && ($urandom_range(0, 1) == 1);
            r    = !w || ($urandom_range(0, 3) == 0);
            drop = !w && ($urandom_range(0, 7) == 0);
            d    = $urandom_range(0, 4);
            rd   = $urandom_range(0, 4);
            a    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            do_txn(r, w, a, $urandom, 4'($urandom), d, rd, drop, $urandom);
            if ($urandom_range(0, 1) == 1) begin
                go_idle($urandom_range(1, 3));
`ifdef UNCACHED_WRITE_POST_EN
                go_idle(6);
                prev_wr = 1'b0;
`endif
            end
        end
        go_idle(8);
        prev_wr = 1'b0;

        // Reset while the read sits in WAIT; its late response must be ignored.
        tx_q.push_back('{0, 6, 1'b0, 32'h5555_AAAA});
        exp_req.push_back('{1'b0, 32'h1FD0_F020, 32'h0, 4'hF});
        uncached_read = 1'b1;
        address       = 32'h1FD0_F020;
        wrdata        = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n         = 1'b0;
        uncached_read = 1'b0;
        #1;
        chk("mid_rst_valid", {127'b0, mem_req_valid}, 128'd0);
        chk("mid_rst_fields", {59'b0, mem_req_write, mem_req_addr, mem_req_wdata,
            mem_req_be}, 128'd0);
        chk("mid_rst_rddata", {96'b0, uncached_rddata}, 128'd0);
        chk("mid_rst_stall", {126'b0, uncached_stall, bus_error}, 128'd0);
        last_rd = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        go_idle(10);
        @(negedge clk);
        chk("late_resp_valid", {127'b0, mem_req_valid}, 128'd0);
        chk("late_resp_rddata", {96'b0, uncached_rddata}, 128'd0);
        go_idle(1);
        do_txn(1, 0, 32'h1FD0_F024, 32'h0, 4'h0, 0, 0, 0, 32'h2468_ACE0);
        go_idle(4);
        chk("exp_req_empty", 128'(exp_req.size()), 128'd0);
        chk("exp_done_empty", 128'(exp_done.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
